// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-path types: widths, FIFO entry bundle, fetch FSM states.
// Used by instr_fetch_unit, fetch_fifo and the fetch interfaces.
package risc_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    RUN,
    ERR
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch bundles: instruction-memory request/response and the
// {pc, instr} valid/ready hand-off to decode.
interface imem_if;
  import risc_pkg::*;

  logic               req;
  logic [XLEN-1:0]    addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata
  );
endinterface

interface fetch_if;
  import risc_pkg::*;

  logic               valid;
  logic               ready;
  logic [XLEN-1:0]    pc;
  logic [INSTR_W-1:0] instr;

  modport master (
    output valid, pc, instr,
    input  ready
  );

  modport slave (
    input  valid, pc, instr,
    output ready
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch FIFO of {pc, instr}; flush wins over push and pop.
// Head entry is read straight from the register array.
module fetch_fifo
  import risc_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);

  localparam int CNTW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = count == '0;
  assign full    = count == CNTW'(DEPTH);
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CNTW'(do_push) - CNTW'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited sequential fetch, prefetch FIFO, redirect flush.
// Optional misaligned-redirect trap enabled by IFU_MISALIGN_CHECK_EN.
module instr_fetch_unit
  import risc_pkg::*;
#(
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            srst,
  imem_if.master          imem,
  fetch_if.master         dec,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err,
  output logic [XLEN-1:0] fetch_err_pc
);

  localparam int         CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int         CRW    = CW + 1;
  localparam logic [0:0] ST_RUN = RUN;
  localparam logic [0:0] ST_ERR = ERR;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] tgt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   fifo_count;
  logic [0:0]      state;
  logic            started;
  logic            mis;
  logic            grant;
  logic            keep;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

`ifdef IFU_MISALIGN_CHECK_EN
  assign mis = |redirect_pc[1:0];
  assign tgt = redirect_pc;

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      fetch_err    <= 1'b0;
      fetch_err_pc <= '0;
    end else if (redirect_valid) begin
      fetch_err    <= mis;
      fetch_err_pc <= mis ? redirect_pc : '0;
    end
  end
`else
  logic unused_lsb;
  assign unused_lsb   = ^redirect_pc[1:0];
  assign mis          = 1'b0;
  assign tgt          = {redirect_pc[XLEN-1:2], 2'b00};
  assign fetch_err    = 1'b0;
  assign fetch_err_pc = '0;
`endif

  // Credit counts stale in-flight words too, so a push never hits a full FIFO.
  assign imem.req  = started && state == ST_RUN && !redirect_valid &&
                     (({1'b0, fifo_count} + {1'b0, outstanding}) <
                      CRW'(FIFO_DEPTH));
  assign imem.addr = fetch_pc;
  assign grant     = imem.req && imem.gnt;
  assign keep      = imem.rvalid && drop_cnt == '0;
  assign pop       = dec.valid && dec.ready;
  assign wr_entry  = '{pc: resp_pc, instr: imem.rdata};

  assign dec.valid = !fifo_empty;
  assign dec.pc    = head.pc;
  assign dec.instr = head.instr;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (srst),
    .push  (keep),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      state       <= ST_RUN;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding + CW'(grant) - CW'(imem.rvalid);
      if (redirect_valid) begin
        fetch_pc <= tgt;
        resp_pc  <= tgt;
        drop_cnt <= outstanding - CW'(imem.rvalid);
        state    <= mis ? ST_ERR : ST_RUN;
      end else begin
        if (grant) fetch_pc <= fetch_pc + XLEN'(4);
        if (keep) resp_pc <= resp_pc + XLEN'(4);
        if (imem.rvalid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
  end

  a_out_no_uflow: assert property (@(posedge clk) disable iff (srst)
    imem.rvalid |-> outstanding != '0);
  a_out_no_oflow: assert property (@(posedge clk) disable iff (srst)
    outstanding <= CW'(FIFO_DEPTH));
  a_drop_bounded: assert property (@(posedge clk) disable iff (srst)
    drop_cnt <= outstanding);
  a_no_push_full: assert property (@(posedge clk) disable iff (srst)
    !(keep && fifo_full && !redirect_valid));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-configurable memory model and an
// expected-fetch scoreboard popped on every decode hand-off.
module tb_instr_fetch_unit;
  import risc_pkg::*;

  localparam int              DEPTH  = 4;
  localparam logic [XLEN-1:0] RST_PC = '0;

  logic            clk = 1'b0;
  logic            srst = 1'b1;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            fetch_err;
  logic [XLEN-1:0] fetch_err_pc;

  imem_if  imem ();
  fetch_if dec ();

  instr_fetch_unit #(
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (RST_PC)
  ) dut (
    .clk            (clk),
    .srst           (srst),
    .imem           (imem),
    .dec            (dec),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err),
    .fetch_err_pc   (fetch_err_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t sb[$];

  int checks = 0;
  int failures = 0;
  int cyc;
  int lat;
  int first_valid;
  bit gnt_en;
  bit post_redir;
  bit want_first;
  bit did_redir;
  bit last_req;
  bit last_valid;
  logic [XLEN-1:0] exp_fetch;
  logic [XLEN-1:0] first_pop_pc;

  function automatic logic [31:0] word_of(input logic [XLEN-1:0] a);
    return a ^ 32'hC0DE_0003;
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive at negedge, sample #1 later, then step to next negedge.
  // mode: 0 none, 1 redirect, 2 when >=3 in flight, 3 on rvalid+pop race.
  task automatic cycle(input bit rdy, input int mode,
                       input logic [XLEN-1:0] rpc);
    int           pre;
    bit           redir;
    fetch_entry_t e;
    pre = mq.size();
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem.rvalid = 1'b1;
      imem.rdata  = word_of(mq[0].addr);
      void'(mq.pop_front());
    end
    imem.gnt  = gnt_en;
    dec.ready = rdy;
    case (mode)
      1:       redir = 1'b1;
      2:       redir = pre >= 3;
      3:       redir = imem.rvalid && dec.valid && rdy && mq.size() > 0;
      default: redir = 1'b0;
    endcase
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    last_req   = imem.req;
    last_valid = dec.valid;
    did_redir  = redir;
    if (dec.valid && first_valid < 0) first_valid = cyc;
    if (imem.req && imem.gnt) mq.push_back('{imem.addr, cyc + lat});
    if (redir) begin
      check("req_in_redirect", imem.req, 0);
      sb.delete();
      post_redir = 1'b1;
      want_first = 1'b1;
`ifdef IFU_MISALIGN_CHECK_EN
      exp_fetch = rpc;
`else
      exp_fetch = {rpc[XLEN-1:2], 2'b00};
`endif
    end else begin
      if (post_redir) check("valid_after_redirect", dec.valid, 0);
      post_redir = 1'b0;
      if (imem.req && imem.gnt) begin
        check("imem_addr", imem.addr, exp_fetch);
        sb.push_back('{pc: exp_fetch, instr: word_of(exp_fetch)});
        exp_fetch += 4;
      end
      if (dec.valid && rdy) begin
        if (want_first) begin
          first_pop_pc = dec.pc;
          want_first   = 1'b0;
        end
        if (sb.size() == 0) begin
          check("spurious_valid", dec.valid, 0);
        end else begin
          e = sb.pop_front();
          check("instr_pc", dec.pc, e.pc);
          check("instr", dec.instr, e.instr);
        end
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(rdy, 0, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    gnt_en = 1'b0;
    while ((sb.size() > 0 || mq.size() > 0) && n < 60) begin
      cycle(1'b1, 0, '0);
      n++;
    end
    check("drain_empty", sb.size() + mq.size(), 0);
    gnt_en = 1'b1;
  endtask

  task automatic redirect_when(input int mode, input logic [XLEN-1:0] rpc);
    int n;
    n = 0;
    did_redir = 1'b0;
    while (!did_redir && n < 40) begin
      cycle(1'b1, mode, rpc);
      n++;
    end
    check("redirect_fired", did_redir, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem.req, 0);
    check({tag, "_addr"}, imem.addr, RST_PC);
    check({tag, "_valid"}, dec.valid, 0);
    check({tag, "_pc"}, dec.pc, 0);
    check({tag, "_instr"}, dec.instr, 0);
    check({tag, "_err"}, fetch_err, 0);
  endtask

  initial begin
    imem.gnt    = 1'b0;
    imem.rvalid = 1'b0;
    imem.rdata  = '0;
    dec.ready   = 1'b0;
    cyc         = 0;
    lat         = 1;
    gnt_en      = 1'b1;
    first_valid = -1;
    exp_fetch   = RST_PC;
    post_redir  = 1'b0;
    want_first  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    srst = 1'b0;

    // 1-cycle memory, decode always ready
    cycle(1'b1, 0, '0);
    check("req_cycle0", last_req, 0);
    run(11, 1'b1);
    check("first_valid_cycle", first_valid, 3);

    // decode stall fills the FIFO and throttles requests
    run(10, 1'b0);
    check("stall_req_low", last_req, 0);
    check("stall_valid", last_valid, 1);
    check("stall_fill", sb.size(), DEPTH);
    run(8, 1'b1);
    drain();

    // 3-cycle memory, redirect with three in flight
    lat = 3;
    redirect_when(2, 32'h0000_0100);
    run(12, 1'b1);
    check("redir_target_pc", first_pop_pc, 32'h0000_0100);

    // redirect racing a response and a pop
    run(6, 1'b1);
    redirect_when(3, 32'h0000_0180);
    run(12, 1'b1);
    check("redir_race_pc", first_pop_pc, 32'h0000_0180);
    drain();

    // address wrap at the top of memory
    lat = 1;
    cycle(1'b1, 1, 32'hFFFF_FFF8);
    run(10, 1'b1);
    check("wrap_first_pc", first_pop_pc, 32'hFFFF_FFF8);
    drain();

    // misaligned redirect target
`ifdef IFU_MISALIGN_CHECK_EN
    cycle(1'b1, 1, 32'h0000_0102);
    run(4, 1'b1);
    check("err_flag", fetch_err, 1);
    check("err_pc", fetch_err_pc, 32'h0000_0102);
    check("err_req_low", last_req, 0);
    check("err_valid_low", last_valid, 0);
    drain();
    cycle(1'b1, 1, 32'h0000_0200);
    run(8, 1'b1);
    check("err_cleared", fetch_err, 0);
    check("err_pc_cleared", fetch_err_pc, 0);
    check("err_resume_pc", first_pop_pc, 32'h0000_0200);
`else
    cycle(1'b1, 1, 32'h0000_0102);
    run(8, 1'b1);
    check("misalign_masked_pc", first_pop_pc, 32'h0000_0100);
    check("err_tied_low", fetch_err, 0);
    check("err_pc_tied_low", fetch_err_pc, 0);
`endif
    drain();

    // asynchronous reset in the middle of a burst
    run(5, 1'b1);
    srst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    mq.delete();
    sb.delete();
    post_redir     = 1'b0;
    want_first     = 1'b0;
    imem.rvalid    = 1'b0;
    imem.rdata     = '0;
    imem.gnt       = 1'b0;
    dec.ready      = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    srst        = 1'b0;
    cyc         = 0;
    first_valid = -1;
    exp_fetch   = RST_PC;
    run(8, 1'b1);
    check("rst2_first_valid", first_valid, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
